port_responder: RTL and testbench
=================================

# port_responder

Synthesizable responder for the toggle-style req/ack memory-port protocol used by the `porttest` traffic generators. It answers reads and writes from an internal block RAM with programmable, optionally jittered latency. It replaces the SDRAM controller so that each `porttest` instance, and its error and read counters, can be validated in isolation before testing against real SDRAM. One instance serves one port.

## Interface
Parameters:
- `addrwidth`, 21: MSB index of address bus `a[addrwidth:1]`.
- `datawidth`, 16: initiator write width, 16 or 8.
- `membits`, 10: RAM depth is 2^membits 16-bit words.
- `latency`, 3: base edges from request capture to ack toggle; must be ≥1.
- `jitter`, 0: 1 adds a pseudo-random 0–3 extra edges per transaction.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `a` in addrwidth: word address `a[addrwidth:1]`. For 8-bit ports, `a[1]` is the byte lane.
- `req` in 1: request toggle. A request is pending when `req != ack`.
- `we` in 1: 1 = write, 0 = read. Sampled at capture.
- `d` in datawidth: write data.
- `ack` out 1: acknowledge toggle.
- `q` out 16: read data word. The initiator selects the byte lane for 8-bit ports.
- `busy` out 1: high from the capture edge until the ack edge.
- `viol` out 1: sticky protocol-violation flag.
- `rdcount` out 32: completed reads.
- `wrcount` out 32: completed writes.
- `fault_mask` in 16: present only with `PORTRESP_FAULT_EN`.

## Operation
- **Reset values:** `ack`=0, `q`=0, `busy`=0, `viol`=0, `rdcount`=0, `wrcount`=0, state IDLE, LFSR=16'hACE1. RAM is not reset.
- **Word index:**
  - datawidth=16: `a[membits:1]`.
  - datawidth=8: `a[membits+1:2]`.
  - Higher address bits are ignored, so addresses alias.
- **States: IDLE, WAIT, ACCESS.**
  - IDLE: when `req != ack`, capture `a`, `we`, `d`, and the `req` value; set `busy`=1; load countdown = latency−1+j. Go to ACCESS if countdown is 0, otherwise to WAIT.
  - WAIT: decrement; at 0 go to ACCESS.
  - ACCESS:
    - Write: store captured data. At 8-bit width only the lane selected by captured `a[1]` is written (1 = [15:8], 0 = [7:0]).
    - Read: `q` ← RAM word.
    - Then `ack` ← captured req value, `busy`=0, increment the matching counter, return to IDLE.
- **Jitter:** j = LFSR[1:0] when jitter=1, otherwise 0. The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per capture.
- **Input capture:** `a`, `we`, and `d` are sampled only at capture; later changes do not affect the transaction in flight.
- **Protocol violation:** if `req` changes while `busy`, set `viol`=1 (cleared only by reset). After ack, if `req != ack` still holds, the new request is serviced normally from IDLE.
- **Counter wrap:** counters wrap 32'hFFFFFFFF→0.
- **Write then read:** a write followed immediately by a read of the same word returns the new data.
- **Reset mid-transaction:** the transaction is abandoned and nothing is written. Any write completed at an earlier ACCESS edge persists.

## Timing
- Capture edge N is the first edge with `req != ack` in IDLE.
- `ack` toggles, and `q` updates for reads, at edge N+latency+j. `q` and `ack` change on the same edge.
- Minimum back-to-back interval: the next capture is possible one edge after the ack edge.
- `q` holds its value until the next read's ACCESS edge. Writes do not alter `q`.

## Configuration
- `PORTRESP_FAULT_EN` defined:
  - The `fault_mask` port exists.
  - Read data is `RAM word ^ fault_mask`, sampled at the ACCESS edge.
  - Stored data is never altered.
- Undefined: the port is absent and `q` is the exact RAM word.

## Test plan
- Reset, latency=3, jitter=0: write 16'h1234 at `a`=5 with `req` 0→1 at capture edge N → `ack`=1 at edge N+3, `busy` high for edges N..N+2, `wrcount`=1.
- Read `a`=5 → `q`=16'h1234 on the same edge `ack` toggles; `rdcount`=1.
- datawidth=8: write 8'hAB with `a[1]`=1, then 8'hCD with `a[1]`=0, same word; read → `q`=16'hABCD.
- membits=10, datawidth=16: write 16'h5A5A at `a`=11'h400; read `a`=0 → 16'h5A5A (alias).
- jitter=1, 1000 reads:
  - every ack delay lies in 3..6 edges, and at least two distinct delays occur;
  - toggling `req` twice while busy → `viol`=1 and two acks follow.
- `PORTRESP_FAULT_EN`, `fault_mask`=16'h0001: read of stored 16'h1234 → `q`=16'h1235. With mask 0, a reread returns 16'h1234.

Source files
------------

// File: rtl/port_responder.sv
// Block-RAM responder for the toggle req/ack memory-port protocol with programmable, optionally jittered latency.
// Optional PORTRESP_FAULT_EN adds a fault_mask input that is XORed into read data.
module port_responder #(
  parameter int unsigned addrwidth = 21,
  parameter int unsigned datawidth = 16,
  parameter int unsigned membits   = 10,
  parameter int unsigned latency   = 3,
  parameter int unsigned jitter    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [addrwidth:1]   a,
  input  logic                 req,
  input  logic                 we,
  input  logic [datawidth-1:0] d,
`ifdef PORTRESP_FAULT_EN
  input  logic [15:0]          fault_mask,
`endif
  output logic                 ack,
  output logic [15:0]          q,
  output logic                 busy,
  output logic                 viol,
  output logic [31:0]          rdcount,
  output logic [31:0]          wrcount
);

  localparam int unsigned IDX_LO    = (datawidth == 8) ? 2 : 1;
  localparam int unsigned DEPTH     = 1 << membits;
  localparam int unsigned CW        = $clog2(latency + 4);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [membits-1:0]     idx_q, idx_d;
  logic                   lane_q, lane_d;
  logic                   we_q, we_d;
  logic [datawidth-1:0]   dat_q, dat_d;
  logic                   rv_q, rv_d;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   viol_q, viol_d;
  logic                   req_prev_q;
  logic [31:0]            rdcnt_q, rdcnt_d;
  logic [31:0]            wrcnt_q, wrcnt_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [15:0]            q_q, q_d;

  logic [15:0]            mem [DEPTH];
  logic [15:0]            rd_word_c;
  logic [15:0]            wr_word_c;
  logic [15:0]            d_ext_c;
  logic                   mem_we_c;
  logic [CW-1:0]          jit_c;
  logic [CW-1:0]          load_c;
  logic [15:0]            rd_mask_c;
  logic                   unused_c;

`ifdef PORTRESP_FAULT_EN
  assign rd_mask_c = fault_mask;
`else
  assign rd_mask_c = 16'h0000;
`endif

  assign rd_word_c = mem[idx_q];
  assign d_ext_c   = 16'(dat_q);
  assign jit_c     = (jitter != 0) ? CW'(lfsr_q[1:0]) : '0;
  assign load_c    = CW'(latency - 1) + jit_c;
  assign unused_c  = ^{a, d_ext_c, lane_q};

  // Byte-lane merge for 8-bit initiators; full word otherwise
  always_comb begin
    wr_word_c = d_ext_c;
    if (datawidth == 8) begin
      wr_word_c = lane_q ? {d_ext_c[7:0], rd_word_c[7:0]}
                         : {rd_word_c[15:8], d_ext_c[7:0]};
    end
  end

  assign mem_we_c = (state_q == ACCESS) && we_q;

  // RAM contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[idx_q] <= wr_word_c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    we_d    = we_q;
    dat_d   = dat_q;
    rv_d    = rv_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    rdcnt_d = rdcnt_q;
    wrcnt_d = wrcnt_q;
    lfsr_d  = lfsr_q;
    q_d     = q_q;
    // A req edge while a transaction is in flight is a sticky violation
    viol_d  = viol_q | (busy_q & (req != req_prev_q));

    unique case (state_q)
      IDLE: begin
        if (req != ack_q) begin
          idx_d   = a[IDX_LO +: membits];
          lane_d  = a[1];
          we_d    = we;
          dat_d   = d;
          rv_d    = req;
          busy_d  = 1'b1;
          cnt_d   = load_c;
          lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
          state_d = (load_c == '0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          wrcnt_d = wrcnt_q + 32'd1;
        end else begin
          q_d     = rd_word_c ^ rd_mask_c;
          rdcnt_d = rdcnt_q + 32'd1;
        end
        ack_d   = rv_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      lane_q     <= 1'b0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      rv_q       <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      viol_q     <= 1'b0;
      req_prev_q <= 1'b0;
      rdcnt_q    <= '0;
      wrcnt_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      we_q       <= we_d;
      dat_q      <= dat_d;
      rv_q       <= rv_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      viol_q     <= viol_d;
      req_prev_q <= req;
      rdcnt_q    <= rdcnt_d;
      wrcnt_q    <= wrcnt_d;
      lfsr_q     <= lfsr_d;
      q_q        <= q_d;
    end
  end

  assign ack     = ack_q;
  assign q       = q_q;
  assign busy    = busy_q;
  assign viol    = viol_q;
  assign rdcount = rdcnt_q;
  assign wrcount = wrcnt_q;

endmodule

// File: tb/tb_port_responder.sv
// Directed bench for port_responder: 16-bit, 8-bit and jittered instances; fault mask when PORTRESP_FAULT_EN is set.
module tb_port_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16-bit, latency 3, no jitter
  logic        rst16_n, req16, we16, ack16, busy16, viol16;
  logic [21:1] a16;
  logic [15:0] d16, q16, fm16;
  logic [31:0] rd16, wr16;
  // 8-bit initiator
  logic        rst8_n, req8, we8, ack8, busy8, viol8;
  logic [21:1] a8;
  logic [7:0]  d8;
  logic [15:0] q8;
  logic [31:0] rd8, wr8;
  // jittered
  logic        rstj_n, reqj, wej, ackj, busyj, violj;
  logic [21:1] aj;
  logic [15:0] dj, qj;
  logic [31:0] rdj, wrj;

  port_responder #(.addrwidth(21), .datawidth(16), .membits(10), .latency(3), .jitter(0)) u_dut16 (
    .clk(clk), .reset_n(rst16_n), .a(a16), .req(req16), .we(we16), .d(d16),
`ifdef PORTRESP_FAULT_EN
    .fault_mask(fm16),
`endif
    .ack(ack16), .q(q16), .busy(busy16), .viol(viol16), .rdcount(rd16), .wrcount(wr16));

  port_responder #(.addrwidth(21), .datawidth(8), .membits(10), .latency(3), .jitter(0)) u_dut8 (
    .clk(clk), .reset_n(rst8_n), .a(a8), .req(req8), .we(we8), .d(d8),
`ifdef PORTRESP_FAULT_EN
    .fault_mask(16'h0000),
`endif
    .ack(ack8), .q(q8), .busy(busy8), .viol(viol8), .rdcount(rd8), .wrcount(wr8));

  port_responder #(.addrwidth(21), .datawidth(16), .membits(10), .latency(3), .jitter(1)) u_dutj (
    .clk(clk), .reset_n(rstj_n), .a(aj), .req(reqj), .we(wej), .d(dj),
`ifdef PORTRESP_FAULT_EN
    .fault_mask(16'h0000),
`endif
    .ack(ackj), .q(qj), .busy(busyj), .viol(violj), .rdcount(rdj), .wrcount(wrj));

  // Drivers: called at posedge+1; toggle req and return edges from capture to ack (-1 on timeout)
  task automatic txn16(input logic w, input logic [21:1] addr, input logic [15:0] data, output int lat);
    logic old;
    a16 = addr; we16 = w; d16 = data; old = ack16; req16 = ~req16; lat = -1;
    for (int i = 1; i <= 50 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (ack16 !== old) lat = i - 1;
    end
  endtask

  task automatic txn8(input logic w, input logic [21:1] addr, input logic [7:0] data, output int lat);
    logic old;
    a8 = addr; we8 = w; d8 = data; old = ack8; req8 = ~req8; lat = -1;
    for (int i = 1; i <= 50 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (ack8 !== old) lat = i - 1;
    end
  endtask

  task automatic txnj(input logic w, input logic [21:1] addr, input logic [15:0] data, output int lat);
    logic old;
    aj = addr; wej = w; dj = data; old = ackj; reqj = ~reqj; lat = -1;
    for (int i = 1; i <= 50 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (ackj !== old) lat = i - 1;
    end
  endtask

  task automatic test_reset;
    rst16_n = 1'b0; rst8_n = 1'b0; rstj_n = 1'b0;
    req16 = 0; we16 = 0; a16 = '0; d16 = '0; fm16 = '0;
    req8 = 0; we8 = 0; a8 = '0; d8 = '0;
    reqj = 0; wej = 0; aj = '0; dj = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack16 !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack16); end
    checks++; if (q16 !== 16'h0) begin errors++; $display("FAIL reset_q got=%h exp=0000", q16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy16); end
    checks++; if (viol16 !== 1'b0) begin errors++; $display("FAIL reset_viol got=%b exp=0", viol16); end
    checks++; if (rd16 !== 32'd0 || wr16 !== 32'd0) begin errors++; $display("FAIL reset_counts rd=%0d wr=%0d exp=0/0", rd16, wr16); end
    checks++; if (ack8 !== 1'b0 || ackj !== 1'b0 || busyj !== 1'b0) begin errors++; $display("FAIL reset_others ack8=%b ackj=%b busyj=%b exp=0", ack8, ackj, busyj); end
    rst16_n = 1'b1; rst8_n = 1'b1; rstj_n = 1'b1;
  endtask

  task automatic test_write_latency;
    a16 = 21'd5; we16 = 1'b1; d16 = 16'h1234; req16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (busy16 !== 1'b1 || ack16 !== 1'b0) begin errors++; $display("FAIL wr_busy_edge%0d busy=%b ack=%b exp busy=1 ack=0", i, busy16, ack16); end
    end
    @(posedge clk); #1;
    checks++; if (ack16 !== 1'b1 || busy16 !== 1'b0) begin errors++; $display("FAIL wr_ack ack=%b busy=%b exp ack=1 busy=0", ack16, busy16); end
    checks++; if (wr16 !== 32'd1 || rd16 !== 32'd0) begin errors++; $display("FAIL wr_count wr=%0d rd=%0d exp 1/0", wr16, rd16); end
  endtask

  task automatic test_read;
    a16 = 21'd5; we16 = 1'b0; req16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q16 !== 16'h0 || ack16 !== 1'b1) begin errors++; $display("FAIL rd_early q=%h ack=%b exp q=0000 ack=1", q16, ack16); end
    @(posedge clk); #1;
    checks++; if (q16 !== 16'h1234 || ack16 !== 1'b0) begin errors++; $display("FAIL rd_data q=%h ack=%b exp q=1234 ack=0", q16, ack16); end
    checks++; if (rd16 !== 32'd1) begin errors++; $display("FAIL rd_count got=%0d exp=1", rd16); end
  endtask

  task automatic test_back_to_back;
    int lat;
    txn16(1'b1, 21'd7, 16'hBEEF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_wr_lat got=%0d exp=3", lat); end
    txn16(1'b0, 21'd7, 16'h0000, lat);
    checks++; if (lat !== 3 || q16 !== 16'hBEEF) begin errors++; $display("FAIL b2b_rd lat=%0d q=%h exp lat=3 q=beef", lat, q16); end
    txn16(1'b1, 21'd9, 16'h1111, lat);
    checks++; if (q16 !== 16'hBEEF) begin errors++; $display("FAIL q_hold_on_write got=%h exp=beef", q16); end
    checks++; if (wr16 !== 32'd3 || rd16 !== 32'd2) begin errors++; $display("FAIL b2b_counts wr=%0d rd=%0d exp 3/2", wr16, rd16); end
  endtask

  task automatic test_alias;
    int lat;
    txn16(1'b1, 21'h400, 16'h5A5A, lat);
    txn16(1'b0, 21'h000, 16'h0000, lat);
    checks++; if (q16 !== 16'h5A5A) begin errors++; $display("FAIL alias got=%h exp=5a5a", q16); end
  endtask

  task automatic test_reset_mid;
    int lat;
    a16 = 21'd5; we16 = 1'b1; d16 = 16'hDEAD; req16 = ~req16;
    @(posedge clk); #1;
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy16); end
    @(posedge clk); #1;
    rst16_n = 1'b0; req16 = 1'b0;
    #1;
    checks++; if (busy16 !== 1'b0 || ack16 !== 1'b0 || wr16 !== 32'd0 || q16 !== 16'h0) begin
      errors++; $display("FAIL mid_reset busy=%b ack=%b wr=%0d q=%h exp 0/0/0/0000", busy16, ack16, wr16, q16); end
    @(posedge clk); #1;
    rst16_n = 1'b1;
    txn16(1'b0, 21'd5, 16'h0000, lat);
    checks++; if (q16 !== 16'h1234 || rd16 !== 32'd1) begin errors++; $display("FAIL mid_no_write q=%h rd=%0d exp 1234/1", q16, rd16); end
  endtask

  task automatic test_byte_lanes;
    int lat;
    txn8(1'b1, 21'd7, 8'hAB, lat);
    txn8(1'b1, 21'd6, 8'hCD, lat);
    txn8(1'b0, 21'd6, 8'h00, lat);
    checks++; if (q8 !== 16'hABCD) begin errors++; $display("FAIL lanes got=%h exp=abcd", q8); end
    txn8(1'b1, 21'd6, 8'h11, lat);
    txn8(1'b0, 21'd7, 8'h00, lat);
    checks++; if (q8 !== 16'hAB11) begin errors++; $display("FAIL lane_keep got=%h exp=ab11", q8); end
    checks++; if (wr8 !== 32'd3 || rd8 !== 32'd2 || lat !== 3) begin errors++; $display("FAIL lane_counts wr=%0d rd=%0d lat=%0d exp 3/2/3", wr8, rd8, lat); end
  endtask

  task automatic test_jitter;
    int lat, bad, distinct;
    bit seen [8];
    bad = 0; distinct = 0;
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      txnj(1'b0, 21'(i), 16'h0000, lat);
      if (lat < 3 || lat > 6) bad++;
      else seen[lat] = 1'b1;
    end
    for (int i = 0; i < 8; i++) if (seen[i]) distinct++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL jitter_range out_of_range=%0d exp=0", bad); end
    checks++; if (distinct < 2) begin errors++; $display("FAIL jitter_spread distinct=%0d exp>=2", distinct); end
    checks++; if (rdj !== 32'd1000 || violj !== 1'b0) begin errors++; $display("FAIL jitter_counts rd=%0d viol=%b exp 1000/0", rdj, violj); end
  endtask

  task automatic test_violation;
    int acks;
    logic prev;
    wej = 1'b0; aj = 21'd3; reqj = ~reqj;
    @(posedge clk); #1;
    reqj = ~reqj;
    acks = 0; prev = ackj;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ackj !== prev) begin acks++; prev = ackj; end
    end
    checks++; if (violj !== 1'b1) begin errors++; $display("FAIL viol_flag got=%b exp=1", violj); end
    checks++; if (acks !== 2 || ackj !== reqj || busyj !== 1'b0) begin
      errors++; $display("FAIL viol_acks acks=%0d ack=%b req=%b busy=%b exp 2 acks, ack=req, idle", acks, ackj, reqj, busyj); end
    checks++; if (viol16 !== 1'b0) begin errors++; $display("FAIL viol_clean got=%b exp=0", viol16); end
  endtask

`ifdef PORTRESP_FAULT_EN
  task automatic test_fault;
    int lat;
    fm16 = 16'h0000;
    txn16(1'b1, 21'd20, 16'h1234, lat);
    fm16 = 16'h0001;
    txn16(1'b0, 21'd20, 16'h0000, lat);
    checks++; if (q16 !== 16'h1235) begin errors++; $display("FAIL fault_mask got=%h exp=1235", q16); end
    fm16 = 16'h0000;
    txn16(1'b0, 21'd20, 16'h0000, lat);
    checks++; if (q16 !== 16'h1234) begin errors++; $display("FAIL fault_clear got=%h exp=1234", q16); end
  endtask
`endif

  initial begin
    test_reset;
    test_write_latency;
    test_read;
    test_back_to_back;
    test_alias;
    test_reset_mid;
    test_byte_lanes;
    test_jitter;
    test_violation;
`ifdef PORTRESP_FAULT_EN
    test_fault;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
